// File: rtl/bp_sac_link_merge_pkg.sv
// ============================================================================
// Module      : bp_sac_link_merge_pkg
// Description : Wormhole header layout helpers shared by the SAC link merger.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_sac_link_merge_pkg;

  // Wormhole header: cord in the low bits, length field directly above it.
  function automatic int unsigned wh_len_lsb(input int unsigned cord_width);
    return cord_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_two_fifo.sv
// ============================================================================
// Module      : bsg_two_fifo
// Description : Two-entry ready/valid FIFO with yumi-style dequeue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_two_fifo #(
  parameter int width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] r_mem [2];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_count;
  logic               w_enq;
  logic               w_deq;

  // Ready depends only on registered occupancy, never on a same-cycle dequeue.
  assign ready_o = (r_count != 2'd2);
  assign v_o     = (r_count != 2'd0);
  assign data_o  = r_mem[r_rptr];
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_deq) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/bp_sac_link_merge.sv
// ============================================================================
// Module      : bp_sac_link_merge
// Description : Round-robin wormhole merge of SAC row links onto one egress.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_sac_link_merge
  import bp_sac_link_merge_pkg::*;
#(
  parameter int num_in_p     = 2,
  parameter int flit_width_p = 64,
  parameter int cord_width_p = 8,
  parameter int len_width_p  = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_in_p*flit_width_p-1:0] data_i,
  input  logic [num_in_p-1:0]              v_i,
  output logic [num_in_p-1:0]              ready_and_o,
  output logic [flit_width_p-1:0]          data_o,
  output logic                             v_o,
  input  logic                             ready_and_i
);

  localparam int c_idx_w   = (num_in_p > 1) ? $clog2(num_in_p) : 1;
  localparam int c_len_lsb = int'(wh_len_lsb(cord_width_p));

  typedef enum logic [0:0] {
    c_idle = 1'b0,
    c_busy = 1'b1
  } state_e;

  state_e                  r_state, w_state_nxt;
  logic [c_idx_w-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [c_idx_w-1:0]      r_lock, w_lock_nxt;
  logic [len_width_p-1:0]  r_cnt, w_cnt_nxt;
  logic [c_idx_w-1:0]      w_winner;
  logic [c_idx_w-1:0]      w_sel;
  logic                    w_found;
  logic                    w_fifo_ready;
  logic                    w_xfer;
  logic [flit_width_p-1:0] w_sel_data;
  logic [len_width_p-1:0]  w_hdr_len;

  // First valid input at or above rr_ptr, wrapping modulo num_in_p.
  always_comb begin
    int j;
    w_found  = 1'b0;
    w_winner = '0;
    j        = 0;
    for (int k = 0; k < num_in_p; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= num_in_p) j = j - num_in_p;
      if (!w_found && v_i[j]) begin
        w_found  = 1'b1;
        w_winner = c_idx_w'(j);
      end
    end
  end

  assign w_sel      = (r_state == c_busy) ? r_lock : w_winner;
  assign w_sel_data = data_i[w_sel*flit_width_p +: flit_width_p];
  assign w_hdr_len  = w_sel_data[c_len_lsb +: len_width_p];

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_lock_nxt   = r_lock;
    w_cnt_nxt    = r_cnt;
    ready_and_o  = '0;
    w_xfer       = 1'b0;

    case (r_state)
      c_idle: if (w_found) ready_and_o[w_winner] = w_fifo_ready & ~reset_i;
      c_busy: ready_and_o[r_lock] = w_fifo_ready & ~reset_i;
      default: ;
    endcase

    w_xfer = |(ready_and_o & v_i);

    if (w_xfer) begin
      if (r_state == c_idle) begin
        w_rr_ptr_nxt = (w_winner == c_idx_w'(num_in_p - 1)) ? '0 : w_winner + 1'b1;
        if (|w_hdr_len) begin
          w_state_nxt = c_busy;
          w_lock_nxt  = w_winner;
          w_cnt_nxt   = w_hdr_len;
        end
      end else begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == len_width_p'(1)) w_state_nxt = c_idle;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= c_idle;
      r_rr_ptr <= '0;
      r_lock   <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_lock   <= w_lock_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  bsg_two_fifo #(
    .width_p (flit_width_p)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ready_o (w_fifo_ready),
    .data_i  (w_sel_data),
    .v_i     (w_xfer),
    .v_o     (v_o),
    .data_o  (data_o),
    .yumi_i  (v_o & ready_and_i)
  );

endmodule

`default_nettype wire
